// File: rtl/hazard_sched.sv
// Hazard/stall scheduler for the 5-stage RV32 pipeline: forwarding selects,
// load-use stall, redirect flushes and multi-cycle EX op sequencing.
// Ports: clk, rst (async, active-low); ID/EX/MEM/WB register ids and controls in;
//   ForwardA_E/ForwardB_E, Stall_F/D/E, Flush_D/E, MulDivDone_E out.
// Optional build macro HAZARD_STATS_EN adds StallCount/FlushCount (32-bit) outputs.
module hazard_sched #(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1_D,
  input  logic [4:0] rs2_D,
  input  logic [4:0] rs1_E,
  input  logic [4:0] rs2_E,
  input  logic [4:0] rd_E,
  input  logic [1:0] ResultSrc_E,
  input  logic       PCSrc_E,
  input  logic       MulDivStart_E,
  input  logic [4:0] rd_M,
  input  logic       RegWrite_M,
  input  logic [4:0] rd_W,
  input  logic       RegWrite_W,
  output logic [1:0] ForwardA_E,
  output logic [1:0] ForwardB_E,
  output logic       Stall_F,
  output logic       Stall_D,
  output logic       Stall_E,
  output logic       Flush_D,
  output logic       Flush_E,
  output logic       MulDivDone_E
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // BUSY cycles between the accepting IDLE cycle and the DONE cycle.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULDIV_CYCLES - 2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lw_stall;
  logic             start_ok;
  logic             busy;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    logic [1:0] s;
    s = 2'b00;
    if (RegWrite_M && rd_M != 5'd0 && rd_M == rs)
      s = 2'b10;
    else if (RegWrite_W && rd_W != 5'd0 && rd_W == rs)
      s = 2'b01;
    return s;
  endfunction

  always_comb begin
    ForwardA_E = fwd_sel(rs1_E);
    ForwardB_E = fwd_sel(rs2_E);
  end

  always_comb begin
    lw_stall = (ResultSrc_E == 2'b01) && (rd_E != 5'd0) &&
               ((rd_E == rs1_D) || (rd_E == rs2_D));
  end

  // A redirect kills the op in EX, so it must not start.
  assign start_ok = MulDivStart_E && !PCSrc_E;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          cnt_d   = CNT_INIT;
          state_d = (CNT_INIT == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0)
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = ((state_q == IDLE) && start_ok) || (state_q == BUSY);
    MulDivDone_E = (state_q == DONE);
    Stall_F      = lw_stall || busy;
    Stall_D      = lw_stall || busy;
    Stall_E      = busy;
    Flush_D      = PCSrc_E;
    // While frozen, the load stays in EX; a bubble would lose it.
    Flush_E      = PCSrc_E || (lw_stall && !busy);
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (Stall_F) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (Flush_D) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: directed vectors, expected values
// queued by the driver and checked by a separate monitor each cycle.
module tb_hazard_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic [1:0] ResultSrc_E;
  logic       PCSrc_E, MulDivStart_E, RegWrite_M, RegWrite_W;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic       Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, MulDivDone_E;
`ifdef HAZARD_STATS_EN
  logic [31:0] StallCount, FlushCount;
`endif

  always #5 clk = ~clk;

  hazard_sched dut (
    .clk(clk), .rst(rst),
    .rs1_D(rs1_D), .rs2_D(rs2_D),
    .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .ResultSrc_E(ResultSrc_E), .PCSrc_E(PCSrc_E),
    .MulDivStart_E(MulDivStart_E),
    .rd_M(rd_M), .RegWrite_M(RegWrite_M),
    .rd_W(rd_W), .RegWrite_W(RegWrite_W),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E),
    .Flush_D(Flush_D), .Flush_E(Flush_E),
    .MulDivDone_E(MulDivDone_E)
`ifdef HAZARD_STATS_EN
    , .StallCount(StallCount), .FlushCount(FlushCount)
`endif
  );

  typedef struct {
    string       nm;
    logic [10:0] v;
    bit          chk;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // {FA, FB, Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Done}
  function automatic logic [10:0] ex(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic sf, input logic sd, input logic se,
                                     input logic fd, input logic fe, input logic dn);
    return {fa, fb, sf, sd, se, fd, fe, dn};
  endfunction

  task automatic push(input string nm, input logic [10:0] v);
    exp_t e;
    e.nm = nm; e.v = v; e.chk = 1'b0; e.sc = '0; e.fc = '0;
    q.push_back(e);
  endtask

  task automatic push_s(input string nm, input logic [10:0] v,
                        input logic [31:0] sc, input logic [31:0] fc);
    exp_t e;
    e.nm = nm; e.v = v; e.chk = 1'b1; e.sc = sc; e.fc = fc;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs1_D = '0; rs2_D = '0; rs1_E = '0; rs2_E = '0; rd_E = '0;
    rd_M = '0; rd_W = '0; ResultSrc_E = '0;
    PCSrc_E = 1'b0; MulDivStart_E = 1'b0;
    RegWrite_M = 1'b0; RegWrite_W = 1'b0;
  endtask

  // Monitor: outputs are combinational and presented every cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [10:0] got;
      e   = q.pop_front();
      got = {ForwardA_E, ForwardB_E, Stall_F, Stall_D, Stall_E,
             Flush_D, Flush_E, MulDivDone_E};
      n_chk++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", e.nm, got, e.v);
      end
      if (e.chk) begin
`ifdef HAZARD_STATS_EN
        n_chk++;
        if (StallCount !== e.sc || FlushCount !== e.fc) begin
          n_fail++;
          $display("FAIL %s_stats: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                   e.nm, StallCount, FlushCount, e.sc, e.fc);
        end
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    clr();
    tick(); push("reset", ex(0,0,0,0,0,0,0,0));
    tick(); rst = 1'b1; push("idle", ex(0,0,0,0,0,0,0,0));

    // Forwarding
    tick(); clr(); rs1_E = 5; rd_M = 5; RegWrite_M = 1; rd_W = 5; RegWrite_W = 1;
    push("fwd_mem_prio", ex(2'b10,0,0,0,0,0,0,0));
    tick(); RegWrite_M = 0;
    push("fwd_wb", ex(2'b01,0,0,0,0,0,0,0));
    tick(); rd_M = 0; rd_W = 0; RegWrite_M = 1; RegWrite_W = 1;
    push("fwd_x0", ex(0,0,0,0,0,0,0,0));
    tick(); clr(); rs1_E = 4; rs2_E = 7; rd_M = 4; RegWrite_M = 1; rd_W = 7; RegWrite_W = 1;
    push("fwd_ab", ex(2'b10,2'b01,0,0,0,0,0,0));

    // Load-use
    tick(); clr(); ResultSrc_E = 2'b01; rd_E = 3; rs2_D = 3;
    push("lu_rs2", ex(0,0,1,1,0,0,1,0));
    tick(); rd_E = 0;
    push("lu_x0", ex(0,0,0,0,0,0,0,0));
    tick(); rd_E = 9; rs1_D = 9; rs2_D = 0;
    push("lu_rs1", ex(0,0,1,1,0,0,1,0));
    tick(); ResultSrc_E = 2'b10;
    push("lu_notload", ex(0,0,0,0,0,0,0,0));

    // Redirect
    tick(); clr(); PCSrc_E = 1;
    push("redir", ex(0,0,0,0,0,1,1,0));
    tick(); clr();
    push("redir_off", ex(0,0,0,0,0,0,0,0));
    tick(); PCSrc_E = 1; ResultSrc_E = 2'b01; rd_E = 3; rs1_D = 3;
    push("redir_lu", ex(0,0,1,1,0,1,1,0));
    tick(); clr(); PCSrc_E = 1; MulDivStart_E = 1;
    push("redir_start", ex(0,0,0,0,0,1,1,0));
    tick(); clr();
    push("redir_nostart", ex(0,0,0,0,0,0,0,0));

    // Multi-cycle op
    tick(); clr(); MulDivStart_E = 1;
    push("md_c1", ex(0,0,1,1,1,0,0,0));
    tick();
    push("md_c2", ex(0,0,1,1,1,0,0,0));
    tick(); ResultSrc_E = 2'b01; rd_E = 3; rs2_D = 3;
    push("md_c3_lu", ex(0,0,1,1,1,0,0,0));
    tick(); ResultSrc_E = 0; rd_E = 0; rs2_D = 0;
    push("md_done", ex(0,0,0,0,0,0,0,1));
    tick(); clr();
    push("md_idle", ex(0,0,0,0,0,0,0,0));
    tick();
    push("md_idle2", ex(0,0,0,0,0,0,0,0));

    // Reset during the second BUSY cycle
    tick(); clr(); MulDivStart_E = 1;
    push("rm_c1", ex(0,0,1,1,1,0,0,0));
    tick();
    push("rm_c2", ex(0,0,1,1,1,0,0,0));
    tick(); #2; rst = 1'b0; MulDivStart_E = 0;
    push("rm_abort", ex(0,0,0,0,0,0,0,0));
    tick();
    push("rm_held", ex(0,0,0,0,0,0,0,0));
    tick(); rst = 1'b1;
    push("rm_rel", ex(0,0,0,0,0,0,0,0));
    for (int i = 0; i < 4; i++) begin
      tick();
      push("rm_nodone", ex(0,0,0,0,0,0,0,0));
    end

    // Statistics run (counters were cleared by the reset above)
    tick(); clr(); ResultSrc_E = 2'b01; rd_E = 3; rs2_D = 3;
    push("st_lu", ex(0,0,1,1,0,0,1,0));
    tick(); clr();
    push("st_gap", ex(0,0,0,0,0,0,0,0));
    tick(); MulDivStart_E = 1;
    push("st_md1", ex(0,0,1,1,1,0,0,0));
    tick();
    push("st_md2", ex(0,0,1,1,1,0,0,0));
    tick();
    push("st_md3", ex(0,0,1,1,1,0,0,0));
    tick();
    push("st_done", ex(0,0,0,0,0,0,0,1));
    tick(); clr();
    push_s("st_after_md", ex(0,0,0,0,0,0,0,0), 32'd4, 32'd0);
    tick(); PCSrc_E = 1;
    push("st_redir", ex(0,0,0,0,0,1,1,0));
    tick(); clr();
    push_s("st_after_redir", ex(0,0,0,0,0,0,0,0), 32'd4, 32'd1);

    for (int i = 0; i < 5 && q.size() > 0; i++)
      @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
